data_sram_resp: RTL and testbench

Responder end of the data SRAM interface driven by the execute stage. It is a single-port, byte-write-enabled synchronous data memory with fixed one-cycle read latency, so the memory stage can consume rdata in the cycle after the request. It also provides out-of-range detection with a sticky error capture and read/write access counters, for bring-up and verification.

---
 rtl/data_sram_resp_pkg.sv | 32 +++
 rtl/data_sram_resp_dsram_bank.sv | 43 ++++
 rtl/data_sram_resp.sv | 103 ++++++++++
 tb/tb_data_sram_resp.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/data_sram_resp_pkg.sv
// rtl/data_sram_resp_pkg.sv - shared defaults and request classification for the data SRAM responder
package data_sram_resp_pkg;

    localparam int unsigned DSRAM_ADDR_W = 14;
    localparam logic [31:0] DSRAM_BASE   = 32'h0000_0000;
    // en + wen + addr + wdata, so requester and bench bundles agree on the request bus width
    localparam int unsigned DSRAM_REQ_WD = 1 + 4 + 32 + 32;

    typedef enum logic [1:0] {
        RESP_NONE  = 2'd0,
        RESP_READ  = 2'd1,
        RESP_WRITE = 2'd2,
        RESP_ERR   = 2'd3
    } resp_kind_t;

    // What the responder does with the request sampled this cycle
    function automatic resp_kind_t classify(input logic en, input logic in_range, input logic [3:0] wen);
        resp_kind_t kind;
        kind = RESP_NONE;
        if (en) begin
            if (!in_range) begin
                kind = RESP_ERR;
            end else if (wen == 4'h0) begin
                kind = RESP_READ;
            end else begin
                kind = RESP_WRITE;
            end
        end
        return kind;
    endfunction

endpackage

// File: rtl/data_sram_resp_dsram_bank.sv
// rtl/data_sram_resp_dsram_bank.sv - 2**ADDR_W x 32 byte-write array with registered write-first read port
module data_sram_resp_dsram_bank #(
    parameter int unsigned ADDR_W = 14
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic [3:0]        i_wen,
    input  logic [ADDR_W-1:0] i_idx,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_rdata;
    logic [31:0] w_merged;

    // Word as it will look after this cycle's byte writes; returned as the read data (write-first)
    always_comb begin
        w_merged = r_mem[i_idx];
        for (int i = 0; i < 4; i++) begin
            if (i_wen[i]) begin
                w_merged[8*i +: 8] = i_wdata[8*i +: 8];
            end
        end
    end

    // Per-byte array update plus output register; no reset so it stays a plain block RAM
    always_ff @(posedge clk) begin
        if (i_en) begin
            for (int i = 0; i < 4; i++) begin
                if (i_wen[i]) begin
                    r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
            r_rdata <= w_merged;
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/data_sram_resp.sv
// rtl/data_sram_resp.sv - data SRAM responder: range check, one-cycle response, error capture, access counters
module data_sram_resp
    import data_sram_resp_pkg::*;
#(
    parameter int unsigned ADDR_W    = DSRAM_ADDR_W,
    parameter logic [31:0] BASE_ADDR = DSRAM_BASE
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        resp_valid,
    output logic        err_pulse,
    output logic        err_sticky,
    output logic [31:0] err_addr,
    output logic [31:0] rd_cnt,
    output logic [31:0] wr_cnt
);

    logic [31:0]       w_off;
    logic              w_in_range;
    logic [ADDR_W-1:0] w_idx;
    resp_kind_t        w_kind;
    logic              w_bank_en;
    logic [31:0]       w_bank_rdata;
    logic              w_unused_ok;

    logic              r_resp_valid;
    logic              r_err_pulse;
    logic              r_err_sticky;
    logic [31:0]       r_err_addr;
    logic [31:0]       r_rd_cnt;
    logic [31:0]       r_wr_cnt;
    // Forces rdata to zero after reset or an out-of-range response, until the next in-range access
    logic              r_zero;

    assign w_off       = data_sram_addr - BASE_ADDR;
    assign w_in_range  = ((w_off >> (ADDR_W + 2)) == 32'd0);
    assign w_idx       = w_off[ADDR_W+1:2];
    assign w_unused_ok = &{1'b0, w_off[1:0]};
    assign w_kind      = classify(data_sram_en, w_in_range, data_sram_wen);

    // Bank is touched only for in-range requests, and never while reset is held
    assign w_bank_en = resetn && ((w_kind == RESP_READ) || (w_kind == RESP_WRITE));

    data_sram_resp_dsram_bank #(
        .ADDR_W (ADDR_W)
    ) u_dsram_bank (
        .clk     (clk),
        .i_en    (w_bank_en),
        .i_wen   (data_sram_wen),
        .i_idx   (w_idx),
        .i_wdata (data_sram_wdata),
        .o_rdata (w_bank_rdata)
    );

    // Response strobes, first-error capture, zero-select and access counters
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_resp_valid <= 1'b0;
            r_err_pulse  <= 1'b0;
            r_err_sticky <= 1'b0;
            r_err_addr   <= 32'd0;
            r_rd_cnt     <= 32'd0;
            r_wr_cnt     <= 32'd0;
            r_zero       <= 1'b1;
        end else begin
            r_resp_valid <= (w_kind != RESP_NONE);
            r_err_pulse  <= (w_kind == RESP_ERR);
            case (w_kind)
                RESP_READ: begin
                    r_rd_cnt <= r_rd_cnt + 32'd1;
                    r_zero   <= 1'b0;
                end
                RESP_WRITE: begin
                    r_wr_cnt <= r_wr_cnt + 32'd1;
                    r_zero   <= 1'b0;
                end
                RESP_ERR: begin
                    r_zero <= 1'b1;
                    if (!r_err_sticky) begin
                        r_err_sticky <= 1'b1;
                        r_err_addr   <= data_sram_addr;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_sram_rdata = r_zero ? 32'd0 : w_bank_rdata;
    assign resp_valid      = r_resp_valid;
    assign err_pulse       = r_err_pulse;
    assign err_sticky      = r_err_sticky;
    assign err_addr        = r_err_addr;
    assign rd_cnt          = r_rd_cnt;
    assign wr_cnt          = r_wr_cnt;

endmodule

// File: tb/tb_data_sram_resp.sv
// tb/tb_data_sram_resp.sv - scoreboard bench for data_sram_resp with directed vectors
module tb_data_sram_resp;

    logic        clk;
    logic        resetn;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        resp_valid;
    logic        err_pulse;
    logic        err_sticky;
    logic [31:0] err_addr;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_checks;
    int   n_errors;
    int   n_pushed;
    int   n_popped;

    data_sram_resp dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .resp_valid      (resp_valid),
        .err_pulse       (err_pulse),
        .err_sticky      (err_sticky),
        .err_addr        (err_addr),
        .rd_cnt          (rd_cnt),
        .wr_cnt          (wr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive one request for one clock; push the expected response when it is accepted
    task automatic req(input logic en, input logic [3:0] wen, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
        exp_t e;
        data_sram_en    = en;
        data_sram_wen   = wen;
        data_sram_addr  = addr;
        data_sram_wdata = wdata;
        if (en) begin
            e.rdata = exp_rdata;
            e.err   = exp_err;
            sb.push_back(e);
            n_pushed++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            req(1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rdata"},      data_sram_rdata, 32'h0);
        check({tag, "_resp_valid"}, {31'd0, resp_valid}, 32'h0);
        check({tag, "_err_pulse"},  {31'd0, err_pulse},  32'h0);
        check({tag, "_err_sticky"}, {31'd0, err_sticky}, 32'h0);
        check({tag, "_err_addr"},   err_addr, 32'h0);
        check({tag, "_rd_cnt"},     rd_cnt, 32'h0);
        check({tag, "_wr_cnt"},     wr_cnt, 32'h0);
    endtask

    // Monitor: every presented response is compared against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (resetn) begin
            if (resp_valid) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL resp_unexpected: got resp_valid=1 rdata=0x%08h expected no response", data_sram_rdata);
                end else begin
                    e = sb.pop_front();
                    n_popped++;
                    if (data_sram_rdata !== e.rdata || err_pulse !== e.err) begin
                        n_errors++;
                        $display("FAIL resp_data: got rdata=0x%08h err=%0b expected rdata=0x%08h err=%0b",
                                 data_sram_rdata, err_pulse, e.rdata, e.err);
                    end
                end
            end else begin
                n_checks++;
                if (err_pulse !== 1'b0) begin
                    n_errors++;
                    $display("FAIL err_pulse_idle: got %0b expected 0", err_pulse);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        n_checks = 0;
        n_errors = 0;
        n_pushed = 0;
        n_popped = 0;
        resetn          = 1'b0;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = 32'h0;
        data_sram_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Basic write then read
        req(1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0);
        req(1'b1, 4'h0, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0);
        check("cnt_wr_1", wr_cnt, 32'd1);
        check("cnt_rd_1", rd_cnt, 32'd1);

        // Byte merge
        req(1'b1, 4'hF,    32'h20, 32'h11223344, 32'h11223344, 1'b0);
        req(1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, 32'h11BB33DD, 1'b0);
        req(1'b1, 4'h0,    32'h20, 32'h0,        32'h11BB33DD, 1'b0);

        // Back-to-back write then read of the same word
        req(1'b1, 4'hF, 32'h30, 32'h5, 32'h5, 1'b0);
        req(1'b1, 4'h0, 32'h30, 32'h0, 32'h5, 1'b0);
        check("cnt_wr_b2b", wr_cnt, 32'd4);
        check("cnt_rd_b2b", rd_cnt, 32'd3);

        // Out-of-range read, then a bad write aliasing word 0x10
        req(1'b1, 4'h0, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
        check("oor_sticky",   {31'd0, err_sticky}, 32'd1);
        check("oor_err_addr", err_addr, 32'h0001_0000);
        check("oor_rd_cnt",   rd_cnt, 32'd3);
        idle(1);
        req(1'b1, 4'hF, 32'h0002_0010, 32'hFFFF_FFFF, 32'h0, 1'b1);
        check("oor2_err_addr", err_addr, 32'h0001_0000);
        check("oor2_wr_cnt",   wr_cnt, 32'd4);
        req(1'b1, 4'h0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0);

        // Idle hold with write enables asserted but en low
        req(1'b1, 4'hF, 32'h50, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0);
        req(1'b1, 4'h0, 32'h50, 32'h0,        32'hCAFEF00D, 1'b0);
        for (int i = 0; i < 5; i++) begin
            req(1'b0, 4'hF, 32'h50, 32'h0BAD_0BAD, 32'h0, 1'b0);
            check("idle_rdata",      data_sram_rdata, 32'hCAFEF00D);
            check("idle_resp_valid", {31'd0, resp_valid}, 32'd0);
        end
        req(1'b1, 4'h0, 32'h50, 32'h0, 32'hCAFEF00D, 1'b0);
        check("idle_wr_cnt", wr_cnt, 32'd5);
        check("idle_rd_cnt", rd_cnt, 32'd6);

        // Reset asserted in the middle of a write stream
        req(1'b1, 4'hF, 32'h40, 32'h12345678, 32'h12345678, 1'b0);
        req(1'b1, 4'hF, 32'h44, 32'h9ABCDEF0, 32'h9ABCDEF0, 1'b0);
        resetn = 1'b0;
        sb.delete();
        n_pushed--;
        #1;
        check_reset_outputs("midreset");
        data_sram_en = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        req(1'b1, 4'h0, 32'h40, 32'h0, 32'h12345678, 1'b0);
        req(1'b1, 4'h0, 32'h44, 32'h0, 32'h9ABCDEF0, 1'b0);
        check("post_reset_rd_cnt", rd_cnt, 32'd2);
        check("post_reset_wr_cnt", wr_cnt, 32'd0);
        idle(2);

        check("sb_drained",    sb.size(), 32'd0);
        check("resp_count",    n_popped, n_pushed);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
